// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control path: opcode patterns,
// FSM state numbering and the datapath mux select codes.
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_B, CLS_ILLEGAL
    } opclass_e;

    localparam logic [10:0] OP_ADD    = 11'b10001011000;
    localparam logic [10:0] OP_SUB    = 11'b11001011000;
    localparam logic [10:0] OP_AND    = 11'b10001010000;
    localparam logic [10:0] OP_ORR    = 11'b10101010000;
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    // CBZ and B carry immediate bits in the low opcode field, so they match under a mask.
    localparam logic [10:0] CBZ_MASK  = 11'b11111111000;
    localparam logic [10:0] CBZ_MATCH = 11'b10110100000;
    localparam logic [10:0] B_MASK    = 11'b11111100000;
    localparam logic [10:0] B_MATCH   = 11'b00010100000;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_OFF  = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/legv8_opcode_decode.sv
// Combinational classification of the 11-bit LEGv8 opcode field into the
// instruction classes the control FSM distinguishes.
module legv8_opcode_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode_i,
    output opclass_e    op_class_o
);

    always_comb begin
        op_class_o = CLS_ILLEGAL;
        if (opcode_i inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) begin
            op_class_o = CLS_R;
        end else if (opcode_i == OP_LDUR) begin
            op_class_o = CLS_LD;
        end else if (opcode_i == OP_STUR) begin
            op_class_o = CLS_ST;
        end else if ((opcode_i & CBZ_MASK) == CBZ_MATCH) begin
            op_class_o = CLS_CBZ;
        end else if ((opcode_i & B_MASK) == B_MATCH) begin
            op_class_o = CLS_B;
        end
    end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// Multi-cycle LEGv8 control FSM: sequences the shared datapath, waits on the
// memory handshake with a timeout, and counts retired instructions.
module legv8_mc_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg2loc,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count
);

    state_e            state_q, state_d;
    logic [7:0]        wait_q, wait_d;
    logic              illegal_q, timeout_q;
    logic [CNT_W-1:0]  count_q;
    opclass_e          op_class;
    logic              is_wait_state, expired, retire, set_illegal;

    legv8_opcode_decode u_decode (
        .opcode_i   (opcode),
        .op_class_o (op_class)
    );

    assign is_wait_state = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    // A mem_ready arriving in the final allowed cycle completes the access instead of expiring.
    assign expired = is_wait_state && !mem_ready &&
                     (({1'b0, wait_q} + 9'd1) == 9'(MEM_TIMEOUT));

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_IDLE:     if (run) state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op_class)
                    CLS_R:           state_d = S_EXEC_R;
                    CLS_LD, CLS_ST:  state_d = S_MEM_ADDR;
                    CLS_CBZ:         state_d = S_BRANCH;
                    CLS_B:           state_d = S_JUMP;
                    default: begin
                        set_illegal = 1'b1;
                        retire      = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (op_class == CLS_ST) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) retire = 1'b1;
            S_EXEC_R:   state_d = S_R_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: retire = 1'b1;
            default:    state_d = S_IDLE;
        endcase
        if (retire) state_d = run ? S_FETCH : S_IDLE;
        if (expired) state_d = S_IDLE;
        wait_d = (is_wait_state && !mem_ready && !expired) ? wait_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire)      count_q   <= count_q + CNT_W'(1);
            if (set_illegal) illegal_q <= 1'b1;
            if (expired)     timeout_q <= 1'b1;
        end
    end

    // Moore decode of the state register; only the FETCH IR/PC load also looks at mem_ready.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg2loc       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALUB_OFF;
                reg2loc   = opcode[7];
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_R_WB:   reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_PASSB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Self-checking bench for legv8_mc_ctrl: instruction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_legv8_mc_ctrl;

    localparam int CNT_W = 8;
    localparam int TMO   = 4;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDI = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] BR   = 11'b00010100000;
    localparam logic [10:0] ILL  = 11'b11111111111;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic run = 1'b0;
    logic [10:0] opcode = 11'd0;
    logic mem_ready = 1'b0;
    logic ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic reg_write, mem_to_reg, reg2loc, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic illegal, mem_timeout;
    logic [CNT_W-1:0] instr_count;

    int nVectors = 0;
    int nMiscompares = 0;

    legv8_mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg2loc(reg2loc),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal(illegal),
        .mem_timeout(mem_timeout), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Control bundle order: ir_write pc_write pc_write_cond i_or_d mem_read mem_write
    // reg_write mem_to_reg reg2loc alu_src_a alu_src_b[2] alu_op[2] pc_source[2]
    logic [15:0] dutCtrl;
    assign dutCtrl = {ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                      reg_write, mem_to_reg, reg2loc, alu_src_a, alu_src_b, alu_op, pc_source};

    function automatic logic [15:0] expCtrl(input int st, input logic rdy, input logic [10:0] op);
        case (st)
            1:  return {rdy, rdy, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
            2:  return {8'b0, op[7], 1'b0, 2'b11, 2'b00, 2'b00};
            3:  return {9'b0, 1'b1, 2'b10, 4'b0};
            4:  return {3'b0, 1'b1, 1'b1, 11'b0};
            5:  return {6'b0, 1'b1, 1'b1, 8'b0};
            6:  return {3'b0, 1'b1, 1'b0, 1'b1, 10'b0};
            7:  return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            8:  return {6'b0, 1'b1, 9'b0};
            9:  return {2'b0, 1'b1, 6'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            10: return {1'b0, 1'b1, 12'b0, 2'b10};
            default: return 16'h0;
        endcase
    endfunction

    // Reference model: an instruction is a list of states decided at DECODE; memory
    // states stall while mem_ready is low and abort after TMO low cycles.
    int mSt = 0;
    int mWait = 0;
    int mPath[$];
    bit mIll = 0;
    bit mTmo = 0;
    logic [CNT_W-1:0] mCnt = '0;

    task automatic modelStep();
        bit retire = 0;
        if ((mSt == 1 || mSt == 4 || mSt == 6) && !mem_ready) begin
            mWait++;
            if (mWait == TMO) begin
                mTmo = 1;
                mSt = 0;
                mWait = 0;
                mPath.delete();
            end
            return;
        end
        mWait = 0;
        case (mSt)
            0: if (run) mSt = 1;
            1: mSt = 2;
            2: begin
                if (opcode == ADD || opcode == SUB || opcode == ANDI || opcode == ORR) begin
                    mPath.push_back(7); mPath.push_back(8);
                end else if (opcode == LDUR) begin
                    mPath.push_back(3); mPath.push_back(4); mPath.push_back(5);
                end else if (opcode == STUR) begin
                    mPath.push_back(3); mPath.push_back(6);
                end else if (opcode ==? 11'b10110100???) begin
                    mPath.push_back(9);
                end else if (opcode ==? 11'b000101?????) begin
                    mPath.push_back(10);
                end else begin
                    mIll = 1;
                end
                if (mPath.size() == 0) retire = 1;
                else mSt = mPath.pop_front();
            end
            default: begin
                if (mPath.size() == 0) retire = 1;
                else mSt = mPath.pop_front();
            end
        endcase
        if (retire) begin
            mCnt = mCnt + CNT_W'(1);
            mSt = run ? 1 : 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mSt = 0;
            mWait = 0;
            mPath.delete();
            mIll = 0;
            mTmo = 0;
            mCnt = '0;
        end else begin
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model.state", 32'(state), 32'(mSt));
        checkOutput("model.ctrl", 32'(dutCtrl), 32'(expCtrl(mSt, mem_ready, opcode)));
        checkOutput("model.illegal", 32'(illegal), 32'(mIll));
        checkOutput("model.mem_timeout", 32'(mem_timeout), 32'(mTmo));
        checkOutput("model.instr_count", 32'(instr_count), 32'(mCnt));
    end

    task automatic applyStimulus(input logic r, input logic [10:0] op, input logic rdy);
        @(posedge clk);
        #1;
        run = r;
        opcode = op;
        mem_ready = rdy;
        #1;
    endtask

    // From IDLE with run low: leaves the DUT in DECODE with run driven low.
    task automatic startInstr(input string tag, input logic [10:0] op);
        applyStimulus(1'b1, op, 1'b1);
        checkOutput({tag, ".idle"}, 32'(state), 32'd0);
        applyStimulus(1'b1, op, 1'b1);
        checkOutput({tag, ".fetch"}, 32'(state), 32'd1);
        checkOutput({tag, ".ir_write"}, 32'(ir_write), 32'd1);
        applyStimulus(1'b0, op, 1'b1);
        checkOutput({tag, ".decode"}, 32'(state), 32'd2);
    endtask

    function automatic logic [10:0] pickOpcode();
        logic [10:0] op;
        case ($urandom_range(0, 9))
            0: op = ADD;
            1: op = SUB;
            2: op = ANDI;
            3: op = ORR;
            4, 5: op = LDUR;
            6: op = STUR;
            7: op = {8'b10110100, 3'($urandom_range(0, 7))};
            8: op = {6'b000101, 5'($urandom_range(0, 31))};
            default: op = 11'($urandom_range(0, 2047));
        endcase
        return op;
    endfunction

    initial begin
        int resetAt;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("reset.state", 32'(state), 32'd0);
        checkOutput("reset.ctrl", 32'(dutCtrl), 32'd0);
        checkOutput("reset.count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD with mem_ready always high, run dropped at R_WB so it parks afterwards
        startInstr("add", ADD);
        checkOutput("add.reg2loc", 32'(reg2loc), 32'd0);
        applyStimulus(1'b0, ADD, 1'b1);
        checkOutput("add.exec", 32'(state), 32'd7);
        checkOutput("add.alu_op", 32'(alu_op), 32'd2);
        checkOutput("add.exec_reg_write", 32'(reg_write), 32'd0);
        applyStimulus(1'b0, ADD, 1'b1);
        checkOutput("add.rwb", 32'(state), 32'd8);
        checkOutput("add.reg_write", 32'(reg_write), 32'd1);
        checkOutput("add.count_before", 32'(instr_count), 32'd0);
        applyStimulus(1'b0, ADD, 1'b1);
        checkOutput("add.park", 32'(state), 32'd0);
        checkOutput("add.count", 32'(instr_count), 32'd1);

        // LDUR with three stalled cycles in MEM_RD
        startInstr("ldur", LDUR);
        checkOutput("ldur.reg2loc", 32'(reg2loc), 32'd1);
        applyStimulus(1'b0, LDUR, 1'b0);
        checkOutput("ldur.addr", 32'(state), 32'd3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, LDUR, (i == 3) ? 1'b1 : 1'b0);
            checkOutput("ldur.memrd", 32'(state), 32'd4);
            checkOutput("ldur.mem_read", 32'(mem_read), 32'd1);
            checkOutput("ldur.rd_reg_write", 32'(reg_write), 32'd0);
        end
        applyStimulus(1'b0, LDUR, 1'b1);
        checkOutput("ldur.wb", 32'(state), 32'd5);
        checkOutput("ldur.wb_ctrl", 32'({reg_write, mem_to_reg}), 32'd3);
        applyStimulus(1'b0, LDUR, 1'b1);
        checkOutput("ldur.count", 32'(instr_count), 32'd2);
        checkOutput("ldur.reg_write_once", 32'(reg_write), 32'd0);

        startInstr("cbz", CBZ);
        applyStimulus(1'b0, CBZ, 1'b1);
        checkOutput("cbz.state", 32'(state), 32'd9);
        checkOutput("cbz.pc_ctrl", 32'({pc_write_cond, pc_write, pc_source}), 32'b1001);
        applyStimulus(1'b0, CBZ, 1'b1);
        checkOutput("cbz.count", 32'(instr_count), 32'd3);

        startInstr("b", BR);
        applyStimulus(1'b0, BR, 1'b1);
        checkOutput("b.state", 32'(state), 32'd10);
        checkOutput("b.pc_ctrl", 32'({pc_write_cond, pc_write, pc_source}), 32'b0110);
        applyStimulus(1'b0, BR, 1'b1);
        checkOutput("b.count", 32'(instr_count), 32'd4);

        startInstr("ill", ILL);
        checkOutput("ill.flag_before", 32'(illegal), 32'd0);
        applyStimulus(1'b0, ILL, 1'b1);
        checkOutput("ill.state", 32'(state), 32'd0);
        checkOutput("ill.flag", 32'(illegal), 32'd1);
        checkOutput("ill.writes", 32'({reg_write, mem_write}), 32'd0);
        checkOutput("ill.count", 32'(instr_count), 32'd5);

        // STUR with mem_ready stuck low times out after TMO MEM_WR cycles
        startInstr("stur", STUR);
        applyStimulus(1'b0, STUR, 1'b0);
        checkOutput("stur.addr", 32'(state), 32'd3);
        for (int i = 0; i < TMO; i++) begin
            applyStimulus(1'b1, STUR, 1'b0);
            checkOutput("stur.memwr", 32'(state), 32'd6);
            checkOutput("stur.mem_write", 32'(mem_write), 32'd1);
        end
        applyStimulus(1'b1, LDUR, 1'b1);
        checkOutput("stur.timeout_state", 32'(state), 32'd0);
        checkOutput("stur.timeout_flag", 32'(mem_timeout), 32'd1);
        checkOutput("stur.count", 32'(instr_count), 32'd5);
        applyStimulus(1'b1, LDUR, 1'b1);
        checkOutput("resume.fetch", 32'(state), 32'd1);
        applyStimulus(1'b1, LDUR, 1'b1);
        applyStimulus(1'b1, LDUR, 1'b0);
        applyStimulus(1'b1, LDUR, 1'b0);
        checkOutput("rst.in_memrd", 32'(state), 32'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.state", 32'(state), 32'd0);
        checkOutput("rst.ctrl", 32'(dutCtrl), 32'd0);
        checkOutput("rst.flags", 32'({illegal, mem_timeout}), 32'd0);
        checkOutput("rst.count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic; opcode only changes while no instruction is in flight
        resetAt = $urandom_range(800, 2200);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            run = ($urandom_range(0, 9) != 0);
            mem_ready = ($urandom_range(0, 4) < 3);
            if (mSt == 0 || mSt == 1) opcode = pickOpcode();
            if (c == resetAt) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
